// File: rtl/game_pkg.sv
// Shared game definitions: direction encodings, move-resolver state enum,
// default debounce length and the direction priority helper.
package game_pkg;

  localparam int unsigned DIR_W                   = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b1000;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_UP    = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_NONE  = 4'b0000;

  typedef enum logic {
    MV_IDLE = 1'b0,
    MV_HELD = 1'b1
  } mv_state_e;

  // Highest-priority direction among the set bits: up > down > left > right.
  function automatic logic [DIR_W-1:0] dir_priority(input logic [DIR_W-1:0] bits);
    logic [DIR_W-1:0] dir;
    dir = DIR_NONE;
    if ((bits & DIR_UP) != DIR_NONE) begin
      dir = DIR_UP;
    end else if ((bits & DIR_DOWN) != DIR_NONE) begin
      dir = DIR_DOWN;
    end else if ((bits & DIR_LEFT) != DIR_NONE) begin
      dir = DIR_LEFT;
    end else if ((bits & DIR_RIGHT) != DIR_NONE) begin
      dir = DIR_RIGHT;
    end
    return dir;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input line: 2-flop synchroniser, stability counter,
// accepted (stable) level, its one-cycle-delayed copy and a registered
// rising-edge pulse.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   raw_i        raw asynchronous button level
//   level_o      debounced level
//   level_dly_o  debounced level delayed by one cycle
//   rise_o       one-cycle pulse, registered, on each debounced rising edge
module debounce_bit
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic level_dly_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             dly_q, rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      dly_q    <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      dly_q    <= stable_q;
      rise_q   <= stable_q & ~dly_q;
    end
  end

  assign level_o     = stable_q;
  assign level_dly_o = dly_q;
  assign rise_o      = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions both players' raw buttons for game_top: every line is
// synchronised and debounced, each move bus is resolved to a single one-hot
// direction (last pressed wins), and one-cycle fire / menu pulses are made.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   pN_move_raw_i[3:0]             raw buttons {left, right, up, down}
//   pN_shoot_raw_i                 raw fire button
//   player_N_move_o[3:0]           resolved direction, one-hot or zero
//   player_N_shoot_o               debounced fire level
//   pN_shoot_pulse_o               one pulse per fire press
//   sel_up_pulse_o/sel_down_pulse_o one pulse per player 1 up/down press
module input_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [DIR_W-1:0] p1_move_raw_i,
  input  logic             p1_shoot_raw_i,
  input  logic [DIR_W-1:0] p2_move_raw_i,
  input  logic             p2_shoot_raw_i,
  output logic [DIR_W-1:0] player_1_move_o,
  output logic [DIR_W-1:0] player_2_move_o,
  output logic             player_1_shoot_o,
  output logic             player_2_shoot_o,
  output logic             p1_shoot_pulse_o,
  output logic             p2_shoot_pulse_o,
  output logic             sel_up_pulse_o,
  output logic             sel_down_pulse_o
);

  localparam int unsigned NUM_PLAYERS      = 2;
  localparam int unsigned LINES_PER_PLAYER = DIR_W + 1;
  localparam int unsigned NUM_LINES        = NUM_PLAYERS * LINES_PER_PLAYER;
  localparam int unsigned SHOOT_OFS        = DIR_W;

  // Line map per player: [DIR_W-1:0] move bus, [DIR_W] fire.
  logic [NUM_LINES-1:0] db_raw, db_lvl, db_dly, db_rise;

  assign db_raw = {p2_shoot_raw_i, p2_move_raw_i, p1_shoot_raw_i, p1_move_raw_i};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i      (clk_i),
      .rst_ni     (reset_i),
      .raw_i      (db_raw[i]),
      .level_o    (db_lvl[i]),
      .level_dly_o(db_dly[i]),
      .rise_o     (db_rise[i])
    );
  end

  logic [NUM_PLAYERS-1:0][DIR_W-1:0] move_dir;

  // Move resolver per player, fed by the debounced levels and their
  // one-cycle-delayed copies so edges are seen the cycle after they settle.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_mv
    localparam int unsigned BASE = g * LINES_PER_PLAYER;

    mv_state_e        state_q, state_d;
    logic [DIR_W-1:0] lvl, dly, rise, fall;
    logic [DIR_W-1:0] dir_q, dir_d;

    assign lvl  = db_lvl[BASE +: DIR_W];
    assign dly  = db_dly[BASE +: DIR_W];
    assign rise = lvl & ~dly;
    assign fall = ~lvl & dly;

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        state_q <= MV_IDLE;
        dir_q   <= DIR_NONE;
      end else begin
        state_q <= state_d;
        dir_q   <= dir_d;
      end
    end

    // Next-state logic.
    always_comb begin
      state_d = state_q;
      case (state_q)
        MV_IDLE: if (rise != DIR_NONE) state_d = MV_HELD;
        MV_HELD: if (lvl == DIR_NONE) state_d = MV_IDLE;
        default: state_d = MV_IDLE;
      endcase
    end

    // Direction logic: a fresh press always wins; losing the current
    // direction while others are held falls back to fixed priority.
    always_comb begin
      dir_d = dir_q;
      case (state_q)
        MV_IDLE: begin
          if (rise != DIR_NONE) dir_d = dir_priority(rise);
        end
        MV_HELD: begin
          if (lvl == DIR_NONE) begin
            dir_d = DIR_NONE;
          end else if (rise != DIR_NONE) begin
            dir_d = dir_priority(rise);
          end else if ((dir_q & fall) != DIR_NONE) begin
            dir_d = dir_priority(lvl);
          end
        end
        default: dir_d = DIR_NONE;
      endcase
    end

    assign move_dir[g] = dir_q;
  end

  assign player_1_move_o  = move_dir[0];
  assign player_2_move_o  = move_dir[1];
  assign player_1_shoot_o = db_lvl[SHOOT_OFS];
  assign player_2_shoot_o = db_lvl[LINES_PER_PLAYER + SHOOT_OFS];
  assign p1_shoot_pulse_o = db_rise[SHOOT_OFS];
  assign p2_shoot_pulse_o = db_rise[LINES_PER_PLAYER + SHOOT_OFS];
  assign sel_up_pulse_o   = db_rise[1];
  assign sel_down_pulse_o = db_rise[0];

  // Delayed levels of the fire lines and edges of the other move lines are
  // not needed downstream.
  logic unused_db;
  assign unused_db = ^{db_dly[SHOOT_OFS], db_dly[LINES_PER_PLAYER + SHOOT_OFS],
                       db_rise[DIR_W-1:2], db_rise[LINES_PER_PLAYER +: DIR_W]};

endmodule
